// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder: adds/subtracts WIDTH-bit operands CHUNK bits per cycle over
// valid/ready handshakes, with an internal accumulator usable as operand A.
module serial_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic [WIDTH-1:0] acc
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] op_a, op_b;
  logic carry, acc_flag, last;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0] s_ch;
  assign a_ch = op_a[idx*CHUNK +: CHUNK];
  assign b_ch = op_b[idx*CHUNK +: CHUNK];
  assign s_ch = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry};
  assign last = idx == IW'(NCHUNK - 1);
  // carry into the MSB is recovered as a^b^sum at that bit, so ovf needs no extra adder
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      acc       <= '0;
      idx       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      acc_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_a     <= in_acc ? acc : in_a;
          op_b     <= in_sub ? ~in_b : in_b;
          carry    <= in_sub;
          acc_flag <= in_acc;
          idx      <= '0;
          in_ready <= 1'b0;
          state    <= CALC;
        end
        CALC: begin
          out_sum[idx*CHUNK +: CHUNK] <= s_ch[CHUNK-1:0];
          carry <= s_ch[CHUNK];
          idx   <= idx + 1'b1;
          if (last) begin
            out_carry <= s_ch[CHUNK];
            out_ovf   <= a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ s_ch[CHUNK-1] ^ s_ch[CHUNK];
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
          if (acc_flag) acc <= out_sum;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder: directed bench over three parameterisations with a result scoreboard.
module tb_serial_chunk_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv[3], isub[3], iacc[3], ordy[3];
  logic [15:0] ia[3], ib[3];
  logic [15:0] m_acc[3];
  wire ir[3], ov[3], oc[3], oo[3];
  wire [15:0] os[3], ac[3];
  wire [7:0] s8, a8;
  wire [3:0] s4, a4;
  logic [17:0] sb[$];
  int n_cmp = 0, n_err = 0;
  assign os[0] = {8'b0, s8};
  assign ac[0] = {8'b0, a8};
  assign os[1] = {12'b0, s4};
  assign ac[1] = {12'b0, a4};

  always #5 clk = ~clk;

  serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(ia[0][7:0]), .in_b(ib[0][7:0]),
    .in_sub(isub[0]), .in_acc(iacc[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(s8),
    .out_carry(oc[0]), .out_ovf(oo[0]), .acc(a8));
  serial_chunk_adder #(.WIDTH(4), .CHUNK(1)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(ia[1][3:0]), .in_b(ib[1][3:0]),
    .in_sub(isub[1]), .in_acc(iacc[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(s4),
    .out_carry(oc[1]), .out_ovf(oo[1]), .acc(a4));
  serial_chunk_adder #(.WIDTH(16), .CHUNK(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(ia[2]), .in_b(ib[2]),
    .in_sub(isub[2]), .in_acc(iacc[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(os[2]),
    .out_carry(oc[2]), .out_ovf(oo[2]), .acc(ac[2]));

  function automatic int wid(input int k);
    return k == 0 ? 8 : k == 1 ? 4 : 16;
  endfunction

  function automatic int lat(input int k);
    return k == 0 ? 4 : k == 1 ? 4 : 1;
  endfunction

  // reference: {ovf, carry, sum} for a w-bit add or subtract
  function automatic logic [17:0] model(input logic [15:0] a, b, input logic sub, input int w);
    logic [16:0] mask, aa, bb, full;
    logic ovf;
    mask = (17'd1 << w) - 17'd1;
    aa   = {1'b0, a} & mask;
    bb   = (sub ? ~{1'b0, b} : {1'b0, b}) & mask;
    full = aa + bb + 17'(sub);
    ovf  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return {ovf, full[w], full[15:0] & mask[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input int k, input logic [15:0] a, b, input logic sub, accop, input int hold);
    logic [17:0] e;
    logic [15:0] ea;
    int n;
    ea = accop ? m_acc[k] : a;
    ia[k] = a; ib[k] = b; isub[k] = sub; iacc[k] = accop; iv[k] = 1'b1;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    sb.push_back(model(ea, b, sub, wid(k)));
    n = 0;
    while (!ov[k] && n < 40) begin
      chk("busy_in_ready", 32'(ir[k]), 0);
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, lat(k));
    e = sb.pop_front();
    chk("result", {oo[k], oc[k], os[k]}, e);
    for (int i = 0; i < hold; i++) begin
      ia[k] = 16'hA5C3 ^ 16'(i); ib[k] = 16'h5A3C; isub[k] = i[0]; iacc[k] = 1'b1; iv[k] = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 32'(ov[k]), 1);
      chk("hold_in_ready", 32'(ir[k]), 0);
      chk("hold_result", {oo[k], oc[k], os[k]}, e);
      chk("hold_acc", ac[k], m_acc[k]);
    end
    iv[k] = 1'b0;
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    if (accop) m_acc[k] = e[15:0];
    chk("post_valid", 32'(ov[k]), 0);
    chk("post_in_ready", 32'(ir[k]), 1);
    chk("post_acc", ac[k], m_acc[k]);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      iv[k] = 0; isub[k] = 0; iacc[k] = 0; ordy[k] = 0; ia[k] = 0; ib[k] = 0; m_acc[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 32'(ir[k]), 1);
      chk("rst_out", {ov[k], oo[k], oc[k], os[k]}, 0);
      chk("rst_acc", ac[k], 0);
    end
    op(0, 16'h0F, 16'h01, 0, 0, 0);
    chk("add_0f_01", {oo[0], oc[0], os[0]}, 18'h00010);
    op(0, 16'hFF, 16'h01, 0, 0, 0);
    op(0, 16'h7F, 16'h01, 0, 0, 0);
    op(0, 16'h05, 16'h07, 1, 0, 0);
    chk("sub_05_07", {oo[0], oc[0], os[0]}, 18'h000FE);
    op(0, 16'h80, 16'h01, 1, 0, 0);
    op(0, 16'h00, 16'h00, 1, 0, 0);
    op(0, 16'h00, 16'h50, 0, 1, 0);
    chk("acc_1", ac[0], 16'h50);
    op(0, 16'h00, 16'h50, 0, 1, 0);
    chk("acc_2", ac[0], 16'hA0);
    op(0, 16'h00, 16'h50, 0, 1, 0);
    chk("acc_3", ac[0], 16'hF0);
    op(0, 16'h00, 16'hF0, 1, 1, 0);
    chk("acc_sub", ac[0], 16'h00);
    op(0, 16'h12, 16'h34, 0, 1, 5);
    op(0, 16'h00, 16'h33, 0, 1, 0);
    ia[0] = 0; ib[0] = 16'h33; isub[0] = 0; iacc[0] = 1; iv[0] = 1;
    @(posedge clk); #1;
    iv[0] = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) m_acc[k] = 0;
    chk("midrst_in_ready", 32'(ir[0]), 1);
    chk("midrst_valid", 32'(ov[0]), 0);
    chk("midrst_acc", ac[0], 0);
    op(0, 16'hC8, 16'h64, 0, 0, 0);
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          op(1, 16'(a), 16'(b), s[0], 0, 0);
    op(2, 16'hFFFF, 16'h0001, 0, 0, 0);
    op(2, 16'h7FFF, 16'h0001, 0, 0, 0);
    op(2, 16'h1234, 16'h4321, 1, 0, 0);
    op(2, 16'h8000, 16'h0001, 1, 0, 2);
    for (int i = 0; i < 8; i++) op(2, 16'($urandom), 16'($urandom), 1'($urandom), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
